// File: rtl/delay_timer_arbiter_pkg.sv
// Shared definitions for the delay timer arbiter: FSM state encoding,
// default widths and a helper that extracts one requester's delay slice.
package delay_timer_arbiter_pkg;

    // Default counter / delay width
    localparam int DEFAULT_W = 16;

    // Upper bounds used by the generic slice helper
    localparam int MAX_N = 8;
    localparam int MAX_W = 32;
    localparam int MAX_BUS = MAX_N * MAX_W;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } dta_state_e;

    // Returns delay slice i of width w from a zero-extended packed delay bus
    function automatic logic [MAX_W-1:0] delay_slice(
        input logic [MAX_BUS-1:0] bus,
        input int                 i,
        input int                 w
    );
        logic [MAX_W-1:0] mask;
        logic [MAX_BUS-1:0] shifted;
        mask    = (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
        shifted = bus >> (i * w);
        return shifted[MAX_W-1:0] & mask;
    endfunction

endpackage

// File: rtl/delay_timer_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first asserted request at
// or above the rotating pointer, wrapping modulo N.
module delay_rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          valid,
    output logic [IW-1:0] winner,
    output logic [N-1:0]  onehot
);

    logic [IW-1:0] idx;

    // Scan from the farthest rotated position down so the nearest request to ptr wins
    always_comb begin
        valid  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = IW'((int'(ptr) + k) % N);
            if (req[idx]) begin
                valid  = 1'b1;
                winner = idx;
            end
        end
    end

    assign onehot = valid ? (N'(1) << winner) : '0;

endmodule

// File: rtl/delay_timer_arbiter.sv
// Shares one down-counting delay timer among N requesters. A round-robin
// pick in IDLE loads the winner's delay; the job either counts down to a
// one-cycle done pulse or is aborted when the owner drops its request.
module delay_timer_arbiter
    import delay_timer_arbiter_pkg::*;
#(
    parameter int N = 4,
    parameter int W = DEFAULT_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] delay,
    output logic [N-1:0]   grant,
    output logic [N-1:0]   done,
    output logic [N-1:0]   aborted,
    output logic           busy,
    output logic [W-1:0]   q
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [1:0]        state;
    logic [IW-1:0]     ptr;
    logic [IW-1:0]     owner;
    logic [IW-1:0]     owner_next_ptr;

    logic              pick_valid;
    logic [IW-1:0]     pick_winner;
    logic [N-1:0]      pick_onehot;

    logic [MAX_BUS-1:0] delay_ext;
    logic [MAX_W-1:0]   delay_wide;
    logic [W-1:0]       delay_sel;

    delay_rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req    (req),
        .ptr    (ptr),
        .valid  (pick_valid),
        .winner (pick_winner),
        .onehot (pick_onehot)
    );

    // The winner's delay is only consumed on the IDLE->RUN load
    assign delay_ext  = MAX_BUS'(delay);
    assign delay_wide = delay_slice(delay_ext, int'(pick_winner), W);
    assign delay_sel  = delay_wide[W-1:0];

    // Pointer moves just past the finishing owner so it becomes lowest priority
    assign owner_next_ptr = (owner == IW'(N - 1)) ? '0 : owner + IW'(1);

    assign busy = (state != IDLE);

    // Arbiter FSM, shared counter, round-robin pointer and pulse outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            grant   <= '0;
            done    <= '0;
            aborted <= '0;
            q       <= '0;
            ptr     <= '0;
            owner   <= '0;
        end else begin
            done    <= '0;
            aborted <= '0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state <= RUN;
                        grant <= pick_onehot;
                        owner <= pick_winner;
                        q     <= delay_sel;
                    end
                end
                RUN: begin
                    if (!req[owner]) begin
                        state   <= IDLE;
                        grant   <= '0;
                        q       <= '0;
                        aborted <= grant;
                        ptr     <= owner_next_ptr;
                    end else if (q == '0) begin
                        state <= DONE;
                        done  <= grant;
                    end else begin
                        q <= q - W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    grant <= '0;
                    q     <= '0;
                    ptr   <= owner_next_ptr;
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                    q     <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_delay_timer_arbiter.sv
// Directed self-checking bench for delay_timer_arbiter (N=4, W=16).
module tb_delay_timer_arbiter;

    localparam int N = 4;
    localparam int W = 16;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N*W-1:0] delay;
    logic [N-1:0]   grant;
    logic [N-1:0]   done;
    logic [N-1:0]   aborted;
    logic           busy;
    logic [W-1:0]   q;

    int checks;
    int passes;
    int failures;

    delay_timer_arbiter #(
        .N (N),
        .W (W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .delay   (delay),
        .grant   (grant),
        .done    (done),
        .aborted (aborted),
        .busy    (busy),
        .q       (q)
    );

    // Free-running clock, period 10
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_delay(input int i, input logic [W-1:0] d);
        delay[i*W +: W] = d;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) passes++;
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Linear directed sequence
    initial begin
        int errs;
        int max_q;
        int order [5];
        checks   = 0;
        passes   = 0;
        failures = 0;
        rst_n    = 1'b0;
        req      = '0;
        delay    = '0;

        // Reset state
        #12;
        check_output("rst_grant", 32'(grant), 32'h0);
        check_output("rst_done", 32'(done), 32'h0);
        check_output("rst_aborted", 32'(aborted), 32'h0);
        check_output("rst_busy", 32'(busy), 32'h0);
        check_output("rst_q", 32'(q), 32'h0);
        rst_n = 1'b1;
        tick();

        // Single job: requester 0, delay 5
        $display("[TB] single request, delay 5");
        req = 4'b0001;
        set_delay(0, 16'd5);
        tick();
        check_output("t1_grant", 32'(grant), 32'h1);
        check_output("t1_q_load", 32'(q), 32'd5);
        check_output("t1_busy", 32'(busy), 32'h1);
        for (int k = 1; k <= 5; k++) begin
            tick();
            check_output("t1_q_count", 32'(q), 32'(5 - k));
            check_output("t1_no_early_done", 32'(done), 32'h0);
        end
        tick();
        check_output("t1_done", 32'(done), 32'h1);
        check_output("t1_grant_in_done", 32'(grant), 32'h1);
        req = 4'b0000;
        tick();
        check_output("t1_done_single", 32'(done), 32'h0);
        check_output("t1_idle_busy", 32'(busy), 32'h0);
        check_output("t1_idle_grant", 32'(grant), 32'h0);

        // Reset pointer, then round-robin with all requesters and zero delays
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        $display("[TB] round robin, all delays 0");
        delay = '0;
        req   = 4'b1111;
        order = '{0, 1, 2, 3, 0};
        for (int j = 0; j < 5; j++) begin
            tick();
            check_output("rr_grant", 32'(grant), 32'(1 << order[j]));
            check_output("rr_q_zero", 32'(q), 32'h0);
            tick();
            check_output("rr_done", 32'(done), 32'(1 << order[j]));
            if (j == 4) req = 4'b0000;
            tick();
            check_output("rr_gap_grant", 32'(grant), 32'h0);
            check_output("rr_gap_busy", 32'(busy), 32'h0);
        end

        // Abort: requester 2 (delay 10) drops at grant+4, requester 3 pending
        $display("[TB] abort by requester 2");
        set_delay(2, 16'd10);
        set_delay(3, 16'd1);
        req = 4'b1100;
        tick();
        check_output("ab_grant", 32'(grant), 32'h4);
        check_output("ab_q_load", 32'(q), 32'd10);
        tick();
        tick();
        tick();
        tick();
        check_output("ab_q_before_drop", 32'(q), 32'd6);
        req = 4'b1000;
        tick();
        check_output("ab_aborted", 32'(aborted), 32'h4);
        check_output("ab_no_done", 32'(done), 32'h0);
        check_output("ab_grant_clear", 32'(grant), 32'h0);
        check_output("ab_q_clear", 32'(q), 32'h0);
        tick();
        check_output("ab_next_grant", 32'(grant), 32'h8);
        check_output("ab_aborted_once", 32'(aborted), 32'h0);
        req = 4'b0000;
        tick();
        check_output("ab3_aborted", 32'(aborted), 32'h8);
        tick();

        // Delay change during RUN is ignored (pointer now 0)
        $display("[TB] delay change during run");
        set_delay(1, 16'd3);
        req = 4'b0010;
        max_q = 0;
        tick();
        check_output("dc_grant", 32'(grant), 32'h2);
        set_delay(1, 16'd100);
        max_q = int'(q);
        for (int k = 0; k < 3; k++) begin
            tick();
            if (int'(q) > max_q) max_q = int'(q);
            check_output("dc_no_done", 32'(done), 32'h0);
        end
        tick();
        check_output("dc_done", 32'(done), 32'h2);
        check_output("dc_q_max", 32'(max_q), 32'd3);
        req = 4'b0000;
        tick();

        // Asynchronous reset mid-job (pointer now 2, requester 0 wins)
        $display("[TB] async reset mid-job");
        set_delay(0, 16'd9);
        req = 4'b0001;
        tick();
        check_output("ar_grant", 32'(grant), 32'h1);
        tick();
        tick();
        check_output("ar_q7", 32'(q), 32'd7);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("ar_grant_clr", 32'(grant), 32'h0);
        check_output("ar_busy_clr", 32'(busy), 32'h0);
        check_output("ar_q_clr", 32'(q), 32'h0);
        check_output("ar_done_clr", 32'(done), 32'h0);
        check_output("ar_aborted_clr", 32'(aborted), 32'h0);
        req = 4'b1000;
        #1;
        rst_n = 1'b1;
        tick();
        check_output("ar_regrant3", 32'(grant), 32'h8);
        check_output("ar_q_load", 32'(q), 32'd1);
        req = 4'b0000;
        tick();
        check_output("ar_abort3", 32'(aborted), 32'h8);
        tick();

        // Maximum delay: counter runs from FFFF to 0 without wrapping
        $display("[TB] max delay");
        set_delay(0, 16'hFFFF);
        req  = 4'b0001;
        errs = 0;
        tick();
        check_output("mx_q_load", 32'(q), 32'hFFFF);
        for (int k = 1; k <= 65535; k++) begin
            tick();
            if (q !== 16'(65535 - k) || done !== 4'b0000) errs++;
        end
        check_output("mx_count_errs", 32'(errs), 32'd0);
        check_output("mx_q_zero", 32'(q), 32'h0);
        tick();
        check_output("mx_done", 32'(done), 32'h1);
        check_output("mx_q_nowrap", 32'(q), 32'h0);
        req = 4'b0000;
        tick();
        check_output("mx_idle", 32'(busy), 32'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
